// File: rtl/counter_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_pkg : direction/mode constants and range check for the up/down counter
// Rev 1.0
// ----------------------------------------------------------------------------
package counter_pkg;

  localparam logic COUNT_UP   = 1'b1;
  localparam logic COUNT_DOWN = 1'b0;
  localparam logic MODE_WRAP  = 1'b0;
  localparam logic MODE_SAT   = 1'b1;

  // True when the count range is representable and ordered.
  function automatic logic range_ok(input int unsigned     width,
                                    input longint unsigned lo,
                                    input longint unsigned hi);
    return (width >= 1) && (width <= 32) && (lo <= hi) && (hi < (64'd1 << width));
  endfunction

endpackage
`default_nettype wire

// File: rtl/counter_term_detect.sv
`default_nettype none
// ----------------------------------------------------------------------------
// counter_term_detect : flags a count sitting at (or past) the bound it moves toward
// Rev 1.0
// ----------------------------------------------------------------------------
module counter_term_detect
  import counter_pkg::*;
#(
  parameter int                      counterWidth = 8,
  parameter logic [counterWidth-1:0] LO_BOUND     = '0,
  parameter logic [counterWidth-1:0] HI_BOUND     = '1
) (
  input  logic [counterWidth-1:0] qn,
  input  logic                    up_dn,
  output logic                    at_boundary
);

  // Out-of-range loaded values count as boundary hits so they fold back into range.
  always_comb begin
    if (up_dn == COUNT_DOWN) begin
      at_boundary = (qn <= LO_BOUND);
    end else begin
      at_boundary = (qn >= HI_BOUND);
    end
  end

endmodule
`default_nettype wire

// File: rtl/param_counter_updown.sv
`default_nettype none
// ----------------------------------------------------------------------------
// param_counter_updown : ranged up/down counter with load, wrap/saturate, cascade TC
// Rev 1.0
// ----------------------------------------------------------------------------
module param_counter_updown
  import counter_pkg::*;
#(
  parameter int              counterWidth = 8,
  parameter longint unsigned startValue   = 0,
  parameter longint unsigned endValue     = (64'd1 << counterWidth) - 64'd1,
  parameter bit              SATURATE     = MODE_WRAP
) (
  input  logic                    clock50,
  input  logic                    MR_n,
  input  logic                    CEP,
  input  logic                    load,
  input  logic [counterWidth-1:0] loadValue,
  input  logic                    up_dn,
  output logic [counterWidth-1:0] Qn_out,
  output logic                    TC_out,
  output logic                    wrap_out
);

  if (!range_ok(counterWidth, startValue, endValue)) begin : g_bad_range
    $fatal(1, "param_counter_updown: need 1<=counterWidth<=32 and startValue<=endValue<2**counterWidth");
  end

  localparam logic [counterWidth-1:0] c_start = startValue[counterWidth-1:0];
  localparam logic [counterWidth-1:0] c_end   = endValue[counterWidth-1:0];
  localparam logic [counterWidth-1:0] c_one   = counterWidth'(1);

  logic [counterWidth-1:0] count_q, count_d;
  logic                    wrap_q, wrap_d;
  logic                    at_boundary;

  counter_term_detect #(
    .counterWidth (counterWidth),
    .LO_BOUND     (c_start),
    .HI_BOUND     (c_end)
  ) u_term_detect (
    .qn          (count_q),
    .up_dn       (up_dn),
    .at_boundary (at_boundary)
  );

  always_comb begin
    count_d = count_q;
    wrap_d  = 1'b0;
    if (load) begin
      count_d = loadValue;
    end else if (CEP) begin
      if (at_boundary) begin
        wrap_d = 1'b1;
        // Wrap jumps to the opposite bound; saturate stays on the bound just reached.
        if (SATURATE == MODE_SAT) begin
          count_d = (up_dn == COUNT_UP) ? c_end : c_start;
        end else begin
          count_d = (up_dn == COUNT_UP) ? c_start : c_end;
        end
      end else if (up_dn == COUNT_UP) begin
        count_d = count_q + c_one;
      end else begin
        count_d = count_q - c_one;
      end
    end
  end

  always_ff @(posedge clock50 or negedge MR_n) begin
    if (!MR_n) begin
      count_q <= c_start;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign Qn_out   = count_q;
  assign wrap_out = wrap_q;
  assign TC_out   = CEP & at_boundary;

endmodule
`default_nettype wire

// File: doc/param_counter_updown.md
# param_counter_updown

Parametrised N-bit synchronous up/down counter with count enable, parallel load, programmable count range and selectable wrap/saturate mode. It generalises the team's free-running counter. Typical uses in the ATMega32A emulator are timer/counter units (TCNT0/1/2), prescalers, stack-pointer style up/down registers and cascaded wide counters. The ripple-enable terminal-count output allows several instances to be chained.

## Interface
- counterWidth, 8, bit width of count register (1..32)
- startValue, 0, lower bound of count range; reset value
- endValue, 2**counterWidth-1, upper bound of count range; must satisfy startValue <= endValue
- SATURATE, 0, 0 = wrap at range boundary, 1 = hold at boundary

- clock50  in  1  system clock, all state updates on rising edge
- MR_n  in  1  master reset, asynchronous, active-low
- CEP  in  1  count enable; counter advances only when high
- load  in  1  synchronous parallel load, active-high
- loadValue  in  counterWidth  value written when load is high
- up_dn  in  1  direction: 1 = count up, 0 = count down
- Qn_out  out  counterWidth  current count value (registered)
- TC_out  out  1  combinational terminal count: CEP & (count at boundary for current direction)
- wrap_out  out  1  registered one-cycle pulse, set in the cycle after a wrap or saturation hit

## Operation
- Priority per rising edge: MR_n low (async) > load > CEP > hold.
- MR_n low: Qn_out = startValue and wrap_out = 0 immediately, independent of the clock. TC_out follows combinationally from the reset value.
- load high: Qn_out <= loadValue, regardless of CEP or up_dn, and wrap_out <= 0. Out-of-range values are loaded unmodified.
- CEP high, load low, up_dn = 1:
  - Qn_out < endValue: Qn_out + 1.
  - Qn_out >= endValue: startValue if SATURATE = 0, otherwise endValue.
- CEP high, load low, up_dn = 0:
  - Qn_out > startValue: Qn_out − 1.
  - Qn_out <= startValue: endValue if SATURATE = 0, otherwise startValue.
- Boundary branch taken: wrap_out <= 1. Any other update, or hold: wrap_out <= 0.
- CEP low, load low: Qn_out holds and wrap_out <= 0.
- Terminal condition is (up_dn & Qn_out >= endValue) | (~up_dn & Qn_out <= startValue), gated by CEP to form TC_out.
- All arithmetic is unsigned, modulo 2**counterWidth. No intermediate result may exceed counterWidth+1 bits.
- Direction change mid-count takes effect on the next enabled edge. It causes no extra wrap.
- If startValue == endValue: every enabled edge hits the boundary, Qn_out stays constant, and wrap_out pulses on every enabled edge.

## Timing
- Qn_out latency: 1 cycle from CEP or load sampled high.
- wrap_out: asserted in the same cycle the counter shows the post-wrap value, for exactly 1 cycle per event.
- TC_out: purely combinational from CEP, up_dn and Qn_out, with zero latency.
  - For cascading: TC_out of stage k drives CEP of stage k+1. Both stages share clock50.
- Reset deassertion is synchronised externally. The block adds no reset synchroniser.
- Reset values: Qn_out = startValue, wrap_out = 0, TC_out = CEP & (startValue terminal condition).

## Structure
- Shared package `counter_pkg`:
  - Direction constants COUNT_UP = 1'b1 and COUNT_DOWN = 1'b0.
  - Mode constants MODE_WRAP = 0 and MODE_SAT = 1.
  - Elaboration-time range check: startValue <= endValue < 2**counterWidth, fatal on violation.
- One sub-module, `counter_term_detect`: combinational boundary comparator (inputs Qn_out and up_dn, output at_boundary). It is reused by TC_out and the next-state logic.
- Top module holds the count register, wrap_out register and next-state mux.

## Test plan
- counterWidth = 4, defaults, CEP = 1, up_dn = 1, from reset:
  - Qn_out steps 0..15, then 0.
  - TC_out high when Qn_out = 15.
  - wrap_out high in the cycle Qn_out = 0 after the wrap.
- startValue = 3, endValue = 9, SATURATE = 0, up_dn = 0, load 5:
  - Qn_out sequence 5, 4, 3, 9, 8.
  - wrap_out pulses once with Qn_out = 9.
- Same range, SATURATE = 1, up_dn = 1, load 8:
  - Qn_out sequence 8, 9, 9, 9.
  - wrap_out high on each hold edge.
  - Switching up_dn to 0 gives 8.
- load and CEP both high with loadValue = 0xA:
  - Qn_out = 0xA next cycle with no increment.
  - wrap_out = 0.
  - With load and CEP low, Qn_out holds for 5 cycles.
- MR_n pulsed low mid-cycle (between edges) with Qn_out = 7:
  - Qn_out = startValue before the next edge.
  - wrap_out = 0.
  - Counting resumes from startValue after release.
- Two instances cascaded, counterWidth = 4 (8-bit total), both up:
  - Combined value 0x0F → 0x10 → … → 0xFF → 0x00.
  - Upper stage advances only on the lower stage's TC_out.
